axi4lite_rr_arbiter: RTL and testbench
======================================

// Module: axi4lite_rr_arbiter
// PURPOSE
//  Shares one AXI4-Lite master port between NUM_REQ simple requesters (single-beat read/write).
//  Arbitrates round-robin, sequences the AW/W/B or AR/R channel handshakes for the winner,
//  and returns a one-cycle response pulse with read data and error status.
//  Sits between on-chip command sources and the AXI4-Lite slave register file in the top.
// PARAMETERS
//  NUM_REQ        2   number of requesters (>=2)
//  ADDR_WIDTH     2   AXI address width
//  DATA_WIDTH     8   AXI data width
//  TIMEOUT_CYCLES 16  watchdog limit; used only with AXI4LITE_ARB_TIMEOUT_EN
// PORTS
//  clk        in   1                    single clock, rising edge
//  rst        in   1                    synchronous, active-high reset
//  req_valid  in   NUM_REQ              per-requester request; held until req_ready
//  req_write  in   NUM_REQ              1=write, 0=read
//  req_addr   in   NUM_REQ*ADDR_WIDTH   flattened; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  req_wdata  in   NUM_REQ*DATA_WIDTH   flattened write data
//  req_ready  out  NUM_REQ              one-hot 1-cycle grant/accept pulse
//  rsp_valid  out  NUM_REQ              one-hot 1-cycle completion pulse
//  rsp_rdata  out  DATA_WIDTH           read data of last completed read
//  rsp_err    out  1                    valid with rsp_valid; 1 = non-OKAY resp or timeout
//  m_awaddr/m_awvalid out, m_awready in;  m_wdata/m_wvalid out, m_wready in
//  m_bresp[1:0]/m_bvalid in, m_bready out;  m_araddr/m_arvalid out, m_arready in
//  m_rdata/m_rresp[1:0]/m_rvalid in, m_rready out
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; rr pointer = NUM_REQ-1 (req 0 wins first). Reset
//   mid-transaction abandons it: every valid/ready output is 0 the next cycle; no rsp issued.
//  IDLE: if any req_valid, winner = first set bit scanning from ptr+1 modulo NUM_REQ. At the edge:
//   latch write/addr/wdata/index, ptr<=winner, req_ready[winner]=1 for the following cycle only.
//   Payload is sampled only at grant; later changes are ignored. A req dropped before grant is not served.
//  WR_REQ: m_awvalid and m_wvalid both 1 from the grant cycle+1; each held until its own
//   handshake and then dropped independently; same-cycle handshakes allowed. Both done -> WR_RSP.
//  WR_RSP: m_bready=1; on m_bvalid -> rsp_valid[idx]=1 next cycle, rsp_err=(m_bresp!=2'b00),
//   rsp_rdata unchanged, state IDLE.
//  RD_REQ: m_arvalid=1 until m_arready -> RD_RSP.
//  RD_RSP: m_rready=1; on m_rvalid -> rsp_rdata<=m_rdata, rsp_err=(m_rresp!=2'b00), rsp_valid pulse.
//  rsp_valid cycle is IDLE: a new grant may be made on that same edge (back-to-back).
//  Min latency, zero-wait slave: req_valid cycle 0 -> AW/W valid cycle 1 -> bready cycle 2 ->
//   rsp_valid cycle 3 (read identical via AR/R).
//  Addresses/data outputs stable from valid assertion until handshake; one transaction outstanding.
//  Fairness: a continuously requesting port is served within NUM_REQ transactions.
//  rsp_err is 0 outside rsp_valid cycles.
// CONFIGURATION
//  AXI4LITE_ARB_TIMEOUT_EN defined: counter cleared on grant, counts every non-IDLE cycle; at
//   TIMEOUT_CYCLES all m_* valids/readies drop, rsp_valid[idx]=1 with rsp_err=1, rsp_rdata
//   unchanged, state IDLE (debug aid; abandons the bus transaction).
//  Undefined: no counter; arbiter waits indefinitely in any state; TIMEOUT_CYCLES ignored.
// STRUCTURE
//  Package axi4lite_arb_pkg: state enum {IDLE,WR_REQ,WR_RSP,RD_REQ,RD_RSP}, AXI resp
//   constants (OKAY=2'b00, SLVERR=2'b10), default widths.
//  Sub-module rr_pick: combinational round-robin picker (req vector + ptr -> one-hot grant, valid).
// TESTING
//  1 req0 write addr 2'h2 data 8'h04, slave zero-wait, bresp OKAY -> awaddr=2, wdata=04, rsp_valid=01 at cycle 3, rsp_err=0.
//  2 req1 read addr 2'h2, rvalid after 3 waits, rdata 8'h04 -> rsp_valid=10, rsp_rdata=8'h04, rsp_err=0.
//  3 req0 and req1 hold writes continuously, 4 transactions -> grant order 0,1,0,1; no port starved.
//  4 awready delayed 2 cycles, wready immediate (and reverse) -> wvalid drops after own handshake; one B; one rsp pulse.
//  5 bresp=2'b10 on write, rresp=2'b10 on read -> rsp_err=1 on each rsp_valid pulse.
//  6 TIMEOUT_EN, TIMEOUT_CYCLES=16, arready held 0 -> rsp_err=1 pulse 16 cycles after grant; without macro stays RD_REQ; rst mid-txn -> all outputs 0 next cycle.

Source files
------------

// File: rtl/axi4lite_rr_arbiter_pkg.sv
// Shared types and constants for the AXI4-Lite round-robin arbiter.
// Build-time option used by the top: AXI4LITE_ARB_TIMEOUT_EN.
package axi4lite_arb_pkg;
   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP} arb_state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int DEF_NUM_REQ        = 2;
   localparam int DEF_ADDR_WIDTH     = 2;
   localparam int DEF_DATA_WIDTH     = 8;
   localparam int DEF_TIMEOUT_CYCLES = 16;

   function automatic logic resp_is_err(input logic [1:0] resp);
      return resp != RESP_OKAY;
   endfunction
endpackage

// File: rtl/axi4lite_rr_arbiter_if.sv
// Requester side plus AXI4-Lite master side of the arbiter in one bundle.
// master = arbiter view; slave = requesters and the AXI slave.
interface axi4lite_rr_arbiter_if
   import axi4lite_arb_pkg::*;
#(
   parameter int NUM_REQ    = DEF_NUM_REQ,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_write;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ-1:0]            rsp_valid;
   logic [DATA_WIDTH-1:0]         rsp_rdata;
   logic                          rsp_err;

   logic [ADDR_WIDTH-1:0] m_awaddr;
   logic                  m_awvalid;
   logic                  m_awready;
   logic [DATA_WIDTH-1:0] m_wdata;
   logic                  m_wvalid;
   logic                  m_wready;
   logic [1:0]            m_bresp;
   logic                  m_bvalid;
   logic                  m_bready;
   logic [ADDR_WIDTH-1:0] m_araddr;
   logic                  m_arvalid;
   logic                  m_arready;
   logic [DATA_WIDTH-1:0] m_rdata;
   logic [1:0]            m_rresp;
   logic                  m_rvalid;
   logic                  m_rready;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output m_awaddr, m_awvalid, m_wdata, m_wvalid, m_bready, m_araddr, m_arvalid, m_rready,
      input  m_awready, m_wready, m_bresp, m_bvalid, m_arready, m_rdata, m_rresp, m_rvalid
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  m_awaddr, m_awvalid, m_wdata, m_wvalid, m_bready, m_araddr, m_arvalid, m_rready,
      output m_awready, m_wready, m_bresp, m_bvalid, m_arready, m_rdata, m_rresp, m_rvalid
   );
endinterface

// File: rtl/axi4lite_rr_arbiter_rr_pick.sv
// Round-robin picker: first requester after i_ptr (wrapping) wins.
// Purely combinational; no backpressure of its own.
module rr_pick #(
   parameter int NUM_REQ = 2,
   parameter int IW      = 1
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IW-1:0]      i_ptr,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [IW-1:0]      o_idx,
   output logic               o_vld
);
   always_comb begin
      int j;
      o_gnt = '0;
      o_idx = '0;
      o_vld = 1'b0;
      j     = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         j = (int'(i_ptr) + k) % NUM_REQ;
         if (!o_vld && i_req[j]) begin
            o_vld    = 1'b1;
            o_gnt[j] = 1'b1;
            o_idx    = IW'(j);
         end
      end
   end
endmodule

// File: rtl/axi4lite_rr_arbiter.sv
// Round-robin share of one AXI4-Lite master port; single-beat, one transaction in flight.
// Latency req_valid->rsp_valid is 3 cycles with a zero-wait slave; requests wait until granted.
// Optional watchdog under AXI4LITE_ARB_TIMEOUT_EN abandons a stalled bus transaction.
module axi4lite_rr_arbiter
   import axi4lite_arb_pkg::*;
#(
   parameter int NUM_REQ        = DEF_NUM_REQ,
   parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                   clk,
   input  logic                   rst,
   axi4lite_rr_arbiter_if.master  bus
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_t            r_state, w_state_nxt;
   logic [IW-1:0]         r_ptr, r_idx, w_win_idx;
   logic [NUM_REQ-1:0]    w_win_gnt, r_req_ready, r_rsp_valid;
   logic                  w_win_vld, w_win_write;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata, r_rsp_rdata;
   logic                  r_awvalid, r_wvalid, r_arvalid, r_rsp_err;
   logic                  w_grant, w_rsp_fire, w_rsp_err, w_rd_load, w_tmo;

   rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
      .i_req (bus.req_valid),
      .i_ptr (r_ptr),
      .o_gnt (w_win_gnt),
      .o_idx (w_win_idx),
      .o_vld (w_win_vld)
   );

   assign w_win_write = bus.req_write[w_win_idx];

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_rsp_fire  = 1'b0;
      w_rsp_err   = 1'b0;
      w_rd_load   = 1'b0;
      unique case (r_state)
         IDLE: if (w_win_vld) begin
            w_grant     = 1'b1;
            w_state_nxt = w_win_write ? WR_REQ : RD_REQ;
         end
         // AW and W complete independently; leave once neither is still pending
         WR_REQ: if ((!r_awvalid || bus.m_awready) && (!r_wvalid || bus.m_wready))
            w_state_nxt = WR_RSP;
         WR_RSP: if (bus.m_bvalid) begin
            w_state_nxt = IDLE;
            w_rsp_fire  = 1'b1;
            w_rsp_err   = resp_is_err(bus.m_bresp);
         end
         RD_REQ: if (bus.m_arready) w_state_nxt = RD_RSP;
         RD_RSP: if (bus.m_rvalid) begin
            w_state_nxt = IDLE;
            w_rsp_fire  = 1'b1;
            w_rsp_err   = resp_is_err(bus.m_rresp);
            w_rd_load   = 1'b1;
         end
         default: w_state_nxt = IDLE;
      endcase
      if (w_tmo && !w_rsp_fire) begin
         w_state_nxt = IDLE;
         w_rsp_fire  = 1'b1;
         w_rsp_err   = 1'b1;
      end
   end

`ifdef AXI4LITE_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] r_tmo_cnt;

   always_ff @(posedge clk) begin
      if (rst || w_grant)       r_tmo_cnt <= '0;
      else if (r_state != IDLE) r_tmo_cnt <= r_tmo_cnt + 1'b1;
   end

   assign w_tmo = (r_state != IDLE) && (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
   // Watchdog compiled out: never fires regardless of the configured limit.
   assign w_tmo = (TIMEOUT_CYCLES < 0);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr       <= IW'(NUM_REQ - 1);
         r_idx       <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_req_ready <= '0;
         r_rsp_valid <= '0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_arvalid   <= 1'b0;
      end else begin
         r_req_ready <= w_grant ? w_win_gnt : '0;
         r_rsp_valid <= w_rsp_fire ? (NUM_REQ'(1) << r_idx) : '0;
         r_rsp_err   <= w_rsp_fire && w_rsp_err;
         if (w_rd_load) r_rsp_rdata <= bus.m_rdata;
         if (w_grant) begin
            r_ptr   <= w_win_idx;
            r_idx   <= w_win_idx;
            r_addr  <= bus.req_addr[w_win_idx*ADDR_WIDTH +: ADDR_WIDTH];
            r_wdata <= bus.req_wdata[w_win_idx*DATA_WIDTH +: DATA_WIDTH];
         end
         r_awvalid <= (w_grant && w_win_write)  || (r_awvalid && !bus.m_awready && !w_tmo);
         r_wvalid  <= (w_grant && w_win_write)  || (r_wvalid  && !bus.m_wready  && !w_tmo);
         r_arvalid <= (w_grant && !w_win_write) || (r_arvalid && !bus.m_arready && !w_tmo);
      end
   end

   assign bus.req_ready = r_req_ready;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_err   = r_rsp_err;
   assign bus.rsp_rdata = r_rsp_rdata;
   assign bus.m_awaddr  = r_addr;
   assign bus.m_awvalid = r_awvalid;
   assign bus.m_wdata   = r_wdata;
   assign bus.m_wvalid  = r_wvalid;
   assign bus.m_bready  = (r_state == WR_RSP);
   assign bus.m_araddr  = r_addr;
   assign bus.m_arvalid = r_arvalid;
   assign bus.m_rready  = (r_state == RD_RSP);
endmodule

// File: tb/tb_axi4lite_rr_arbiter.sv
// Directed bench with expected grants/AXI payloads/responses queued per vector and
// checked by monitors whenever the arbiter presents them.
module tb_axi4lite_rr_arbiter;
   import axi4lite_arb_pkg::*;

   localparam int NR = 2, AW = 2, DW = 8, TMO = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   axi4lite_rr_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
   axi4lite_rr_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO))
      dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {int idx; logic err; logic [DW-1:0] rdata;} rsp_t;
   rsp_t          exp_rsp[$];
   int            exp_gnt[$];
   logic [AW-1:0] exp_awaddr[$], exp_araddr[$];
   logic [DW-1:0] exp_wdata[$];

   int n_cmp = 0, n_bad = 0;
   int last_rsp_cyc = 0, last_gnt_cyc = 0;
   int n_aw = 0, n_w = 0, n_b = 0;

   int            aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
   bit            ar_block = 1'b0;
   logic [1:0]    bresp_cfg = RESP_OKAY, rresp_cfg = RESP_OKAY;
   logic [DW-1:0] rdata_cfg = '0;

   logic [AW-1:0] pay_addr [2][2];
   logic [DW-1:0] pay_data [2][2];
   logic          pay_wr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_wr(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic err, input logic [DW-1:0] rd);
      exp_gnt.push_back(idx);
      exp_awaddr.push_back(a);
      exp_wdata.push_back(d);
      exp_rsp.push_back('{idx: idx, err: err, rdata: rd});
   endtask

   task automatic expect_rd(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] rd,
                            input logic err, input bit push_ar, input bit push_rsp);
      exp_gnt.push_back(idx);
      if (push_ar)  exp_araddr.push_back(a);
      if (push_rsp) exp_rsp.push_back('{idx: idx, err: err, rdata: rd});
   endtask

   // ---------------- monitors ----------------
   initial begin
      int g;
      rsp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (bus.req_ready != '0) begin
               last_gnt_cyc = cyc;
               if (exp_gnt.size() == 0) chk("unexpected_grant", 32'(bus.req_ready), 0);
               else begin
                  g = exp_gnt.pop_front();
                  chk("grant_onehot", 32'(bus.req_ready), 32'(1) << g);
               end
            end
            if (bus.rsp_valid != '0) begin
               last_rsp_cyc = cyc;
               if (exp_rsp.size() == 0) chk("unexpected_rsp", 32'(bus.rsp_valid), 0);
               else begin
                  e = exp_rsp.pop_front();
                  chk("rsp_valid", 32'(bus.rsp_valid), 32'(1) << e.idx);
                  chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                  chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
               end
            end else if (bus.rsp_err !== 1'b0) begin
               chk("rsp_err_outside_pulse", 32'(bus.rsp_err), 0);
            end
         end
      end
   end

   always @(posedge clk) begin
      if (!rst) begin
         if (bus.m_awvalid && bus.m_awready) n_aw++;
         if (bus.m_wvalid && bus.m_wready)   n_w++;
         if (bus.m_bvalid && bus.m_bready)   n_b++;
      end
   end

   // ---------------- AXI slave model (readies/responses set on negedge) ----------------
   initial begin
      int c;
      c = 0; bus.m_awready = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.m_awvalid && !bus.m_awready) begin
            if (c >= aw_wait) begin
               bus.m_awready = 1'b1; c = 0;
               if (exp_awaddr.size() == 0) chk("unexpected_aw", 1, 0);
               else chk("awaddr", 32'(bus.m_awaddr), 32'(exp_awaddr.pop_front()));
            end else c++;
         end else begin
            bus.m_awready = 1'b0;
            if (!bus.m_awvalid) c = 0;
         end
      end
   end

   initial begin
      int c;
      c = 0; bus.m_wready = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.m_wvalid && !bus.m_wready) begin
            if (c >= w_wait) begin
               bus.m_wready = 1'b1; c = 0;
               if (exp_wdata.size() == 0) chk("unexpected_w", 1, 0);
               else chk("wdata", 32'(bus.m_wdata), 32'(exp_wdata.pop_front()));
            end else c++;
         end else begin
            bus.m_wready = 1'b0;
            if (!bus.m_wvalid) c = 0;
         end
      end
   end

   initial begin
      int c;
      c = 0; bus.m_arready = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.m_arvalid && !bus.m_arready) begin
            if (!ar_block && c >= ar_wait) begin
               bus.m_arready = 1'b1; c = 0;
               if (exp_araddr.size() == 0) chk("unexpected_ar", 1, 0);
               else chk("araddr", 32'(bus.m_araddr), 32'(exp_araddr.pop_front()));
            end else c++;
         end else begin
            bus.m_arready = 1'b0;
            if (!bus.m_arvalid) c = 0;
         end
      end
   end

   initial begin
      int c;
      c = 0; bus.m_bvalid = 1'b0; bus.m_bresp = RESP_OKAY;
      forever begin
         @(negedge clk);
         if (bus.m_bvalid) bus.m_bvalid = 1'b0;
         else if (bus.m_bready) begin
            if (c >= b_wait) begin bus.m_bvalid = 1'b1; bus.m_bresp = bresp_cfg; c = 0; end
            else c++;
         end else c = 0;
      end
   end

   initial begin
      int c;
      c = 0; bus.m_rvalid = 1'b0; bus.m_rresp = RESP_OKAY; bus.m_rdata = '0;
      forever begin
         @(negedge clk);
         if (bus.m_rvalid) bus.m_rvalid = 1'b0;
         else if (bus.m_rready) begin
            if (c >= r_wait) begin
               bus.m_rvalid = 1'b1; bus.m_rresp = rresp_cfg; bus.m_rdata = rdata_cfg; c = 0;
            end else c++;
         end else c = 0;
      end
   end

   // ---------------- requester drivers ----------------
   task automatic drive_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.req_valid[i]          = 1'b1;
      bus.req_write[i]          = wr;
      bus.req_addr[i*AW +: AW]  = a;
      bus.req_wdata[i*DW +: DW] = d;
   endtask

   // Scramble payload after grant so late sampling would be visible.
   task automatic drop_req(input int i);
      bus.req_valid[i]          = 1'b0;
      bus.req_addr[i*AW +: AW]  = ~bus.req_addr[i*AW +: AW];
      bus.req_wdata[i*DW +: DW] = ~bus.req_wdata[i*DW +: DW];
   endtask

   task automatic issue(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int t;
      drive_req(i, wr, a, d);
      t = 0;
      do begin @(negedge clk); t++; end while (!bus.req_ready[i] && t < 100);
      if (t >= 100) chk("grant_wait_timeout", 32'(bus.req_ready), 32'(1) << i);
      drop_req(i);
   endtask

   task automatic serve_both(input int per_req);
      int cnt [2];
      int t, i;
      cnt[0] = 0; cnt[1] = 0;
      for (int k = 0; k < 2; k++) drive_req(k, pay_wr, pay_addr[k][0], pay_data[k][0]);
      t = 0;
      while ((cnt[0] < per_req || cnt[1] < per_req) && t < 400) begin
         @(negedge clk); t++;
         if (bus.req_ready != '0) begin
            i = bus.req_ready[1] ? 1 : 0;
            cnt[i]++;
            if (cnt[i] < per_req) drive_req(i, pay_wr, pay_addr[i][cnt[i]], pay_data[i][cnt[i]]);
            else drop_req(i);
         end
      end
      if (t >= 400) chk("serve_both_timeout", 32'(cnt[0] + cnt[1]), 32'(2 * per_req));
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while ((exp_rsp.size() != 0 || exp_gnt.size() != 0) && t < 200) begin
         @(negedge clk); t++;
      end
      if (t >= 200) chk("completion_timeout", 32'(exp_rsp.size()), 0);
      @(negedge clk);
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_req_ready"}, 32'(bus.req_ready), 0);
      chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
      chk({tag, "_rsp_rdata"}, 32'(bus.rsp_rdata), 0);
      chk({tag, "_rsp_err"},   32'(bus.rsp_err), 0);
      chk({tag, "_awvalid"},   32'(bus.m_awvalid), 0);
      chk({tag, "_wvalid"},    32'(bus.m_wvalid), 0);
      chk({tag, "_bready"},    32'(bus.m_bready), 0);
      chk({tag, "_arvalid"},   32'(bus.m_arvalid), 0);
      chk({tag, "_rready"},    32'(bus.m_rready), 0);
   endtask

   initial begin
      #400000;
      $display("FAIL global_time_limit: got stuck expected finish");
      $fatal(1, "time limit");
   end

   // ---------------- directed vectors ----------------
   initial begin
      int t0;
      bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // 1: req0 write, zero-wait slave, rsp on cycle 3
      expect_wr(0, 2'h2, 8'h04, 1'b0, 8'h00);
      t0 = cyc;
      issue(0, 1'b1, 2'h2, 8'h04);
      wait_done();
      chk("t1_latency", 32'(last_rsp_cyc - t0), 3);

      // 2: req1 read with 3 wait cycles on R
      r_wait = 3; rdata_cfg = 8'h04;
      expect_rd(1, 2'h2, 8'h04, 1'b0, 1'b1, 1'b1);
      issue(1, 1'b0, 2'h2, 8'h00);
      wait_done();
      r_wait = 0;

      // 3: both requesters stream writes; pointer sits at 1 so order is 0,1,0,1
      pay_wr = 1'b1;
      pay_addr[0][0] = 2'h1; pay_data[0][0] = 8'h11;
      pay_addr[0][1] = 2'h3; pay_data[0][1] = 8'h33;
      pay_addr[1][0] = 2'h2; pay_data[1][0] = 8'h22;
      pay_addr[1][1] = 2'h0; pay_data[1][1] = 8'h44;
      expect_wr(0, 2'h1, 8'h11, 1'b0, 8'h04);
      expect_wr(1, 2'h2, 8'h22, 1'b0, 8'h04);
      expect_wr(0, 2'h3, 8'h33, 1'b0, 8'h04);
      expect_wr(1, 2'h0, 8'h44, 1'b0, 8'h04);
      serve_both(2);
      wait_done();

      // 4: AW and W handshakes in different cycles, both orders
      n_aw = 0; n_w = 0; n_b = 0;
      aw_wait = 2; w_wait = 0;
      expect_wr(0, 2'h3, 8'hA5, 1'b0, 8'h04);
      issue(0, 1'b1, 2'h3, 8'hA5);
      wait_done();
      aw_wait = 0; w_wait = 2;
      expect_wr(1, 2'h1, 8'h5A, 1'b0, 8'h04);
      issue(1, 1'b1, 2'h1, 8'h5A);
      wait_done();
      chk("t4_aw_handshakes", 32'(n_aw), 2);
      chk("t4_w_handshakes",  32'(n_w), 2);
      chk("t4_b_handshakes",  32'(n_b), 2);
      w_wait = 0;

      // 5: error responses on write and read
      bresp_cfg = RESP_SLVERR; b_wait = 1;
      expect_wr(0, 2'h0, 8'h77, 1'b1, 8'h04);
      issue(0, 1'b1, 2'h0, 8'h77);
      wait_done();
      rresp_cfg = RESP_SLVERR; rdata_cfg = 8'hC3; ar_wait = 1;
      expect_rd(1, 2'h3, 8'hC3, 1'b1, 1'b1, 1'b1);
      issue(1, 1'b0, 2'h3, 8'h00);
      wait_done();
      bresp_cfg = RESP_OKAY; rresp_cfg = RESP_OKAY; b_wait = 0; ar_wait = 0;

      // 6: AR never accepted
      ar_block = 1'b1;
`ifdef AXI4LITE_ARB_TIMEOUT_EN
      expect_rd(0, 2'h1, 8'hC3, 1'b1, 1'b0, 1'b1);
      issue(0, 1'b0, 2'h1, 8'h00);
      wait_done();
      chk("t6_timeout_latency", 32'(last_rsp_cyc - last_gnt_cyc), 32'(TMO));
      chk("t6_arvalid_dropped", 32'(bus.m_arvalid), 0);
      expect_rd(1, 2'h2, 8'h00, 1'b0, 1'b0, 1'b0);
      issue(1, 1'b0, 2'h2, 8'h00);
      repeat (5) @(negedge clk);
`else
      expect_rd(0, 2'h1, 8'h00, 1'b0, 1'b0, 1'b0);
      issue(0, 1'b0, 2'h1, 8'h00);
      repeat (40) @(negedge clk);
      chk("t6_arvalid_held", 32'(bus.m_arvalid), 1);
`endif
      // reset in the middle of the stalled read
      rst = 1'b1;
      @(negedge clk);
      check_outputs_zero("midrst");
      rst = 1'b0;
      ar_block = 1'b0;
      repeat (3) @(negedge clk);

      // pointer back to NUM_REQ-1: req0 wins first
      pay_wr = 1'b0; rdata_cfg = 8'h99;
      pay_addr[0][0] = 2'h2; pay_data[0][0] = 8'h00;
      pay_addr[1][0] = 2'h3; pay_data[1][0] = 8'h00;
      expect_rd(0, 2'h2, 8'h99, 1'b0, 1'b1, 1'b1);
      expect_rd(1, 2'h3, 8'h99, 1'b0, 1'b1, 1'b1);
      serve_both(1);
      wait_done();

      chk("left_rsp",    32'(exp_rsp.size()), 0);
      chk("left_gnt",    32'(exp_gnt.size()), 0);
      chk("left_aw",     32'(exp_awaddr.size()), 0);
      chk("left_w",      32'(exp_wdata.size()), 0);
      chk("left_ar",     32'(exp_araddr.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
